// File: rtl/press_array_pkg.sv
// Shared types for the button front end: event modes and per-channel FSM states.
package press_pkg;

    // Event mode selected on the mode input; 2'b11 is reserved and behaves like PRESS.
    typedef enum logic [1:0] {
        MODE_RELEASE = 2'b00,
        MODE_PRESS   = 2'b01,
        MODE_REPEAT  = 2'b10
    } mode_t;

    // Per-channel event FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HELD = 2'b01,
        RPT  = 2'b10
    } ch_state_t;

endpackage

// File: rtl/press_array_if.sv
// Key pins in, debounced levels and event pulses out.
interface press_array_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] buttons;
    logic [1:0]      mode;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] pulse;
    logic            pulse_any;

    modport master (output buttons, output mode, input level, input pulse, input pulse_any);
    modport slave  (input buttons, input mode, output level, output pulse, output pulse_any);
endinterface

// File: rtl/press_array_channel.sv
// One button channel: two-flop synchroniser, debounce counter, and event FSM.
module press_channel
    import press_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 10,
    parameter int REPEAT_PERIOD   = 3,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button,
    input  logic [1:0] mode,
    output logic       level,
    output logic       pulse,
    output logic       pulse_nxt
);

    localparam int   CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int   RPT_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int   RC_W     = $clog2(RPT_MAX + 1);
    localparam logic INV_BIT  = 1'(ACTIVE_LOW != 0);

    logic             s1_p0;
    logic             s2_p1;
    logic [CNT_W-1:0] cnt;
    logic             lvl_d;
    ch_state_t        state, state_nxt;
    logic [1:0]       ch_mode, ch_mode_nxt;
    logic [RC_W-1:0]  rc, rc_nxt;
    logic             rise, fall;

    assign rise = level & ~lvl_d;
    assign fall = ~level & lvl_d;

    // Synchronise the raw pin; inversion happens first so both flops hold "pressed" polarity.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_p0 <= 1'b0;
            s2_p1 <= 1'b0;
        end else begin
            s1_p0 <= button ^ INV_BIT;
            s2_p1 <= s1_p0;
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (s2_p1 == level) begin
            cnt   <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level <= s2_p1;
            cnt   <= '0;
        end else begin
            cnt   <= cnt + CNT_W'(1);
        end
    end

    // FSM state, latched mode, repeat counter, edge-detect history and registered pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ch_mode <= MODE_RELEASE;
            rc      <= '0;
            lvl_d   <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            state   <= state_nxt;
            ch_mode <= ch_mode_nxt;
            rc      <= rc_nxt;
            lvl_d   <= level;
            pulse   <= pulse_nxt;
        end
    end

    // Next-state: leave IDLE on a press, return to IDLE on release.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (rise) state_nxt = (mode == MODE_REPEAT) ? RPT : HELD;
            HELD: if (fall) state_nxt = IDLE;
            RPT:  if (fall) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: event pulse, mode capture at press, repeat countdown (a release beats a due repeat).
    always_comb begin
        pulse_nxt   = 1'b0;
        ch_mode_nxt = ch_mode;
        rc_nxt      = rc;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    ch_mode_nxt = mode;
                    pulse_nxt   = (mode != MODE_RELEASE);
                    rc_nxt      = RC_W'(REPEAT_DELAY - 1);
                end
            end
            HELD: begin
                if (fall) pulse_nxt = (ch_mode == MODE_RELEASE);
            end
            RPT: begin
                if (fall) begin
                    rc_nxt = '0;
                end else if (rc == '0) begin
                    pulse_nxt = 1'b1;
                    rc_nxt    = RC_W'(REPEAT_PERIOD - 1);
                end else begin
                    rc_nxt = rc - RC_W'(1);
                end
            end
            default: begin
                pulse_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/press_array.sv
// Multi-channel button front end: N_CH independent channels plus a combined event flag.
module press_array
    import press_pkg::*;
#(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 10,
    parameter int REPEAT_PERIOD   = 3,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic          clk,
    input  logic          reset,
    press_array_if.slave  bus
);

    logic [N_CH-1:0] level_w;
    logic [N_CH-1:0] pulse_w;
    logic [N_CH-1:0] pulse_nxt_w;
    logic            pulse_any_r;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        press_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .button    (bus.buttons[g]),
            .mode      (bus.mode),
            .level     (level_w[g]),
            .pulse     (pulse_w[g]),
            .pulse_nxt (pulse_nxt_w[g])
        );
    end

    // Register the OR of next-cycle pulses so pulse_any lines up with pulse.
    always_ff @(posedge clk) begin
        if (reset) pulse_any_r <= 1'b0;
        else       pulse_any_r <= |pulse_nxt_w;
    end

    assign bus.level     = level_w;
    assign bus.pulse     = pulse_w;
    assign bus.pulse_any = pulse_any_r;

endmodule
